int_div_seq: RTL and testbench

INT_DIV_SEQ -- requirements
Module: int_div_seq

---
 rtl/int_div_seq.sv | 137 +++++++++++++
 tb/tb_int_div_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_div_seq.sv
// Sequential radix-2 restoring integer divider: one quotient bit per cycle, WIDTH cycles per op.
// Optional two's-complement mode is enabled with the DIV_SIGNED_EN macro (adds input signed_i).
module int_div_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
`ifdef DIV_SIGNED_EN
  ,
  input  logic             signed_i
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;      // partial remainder, final remainder in DONE
  logic [WIDTH-1:0] quot_q;     // dividend bits shift out as quotient bits shift in
  logic [WIDTH-1:0] divisor_q;
  logic             div_zero_q;
  logic             neg_quot_q;
  logic             neg_rem_q;

  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;
  logic             neg_quot_in, neg_rem_in;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] rem_step, quot_step;
  logic [WIDTH-1:0] rem_final, quot_final;

  assign accept    = (state_q == IDLE) && in_valid_i;
  assign last_step = (state_q == BUSY) && (cnt_q == LAST_STEP);

  // Operand conditioning: the core always divides magnitudes.
  always_comb begin
    dividend_mag = dividend_i;
    divisor_mag  = divisor_i;
    neg_quot_in  = 1'b0;
    neg_rem_in   = 1'b0;
`ifdef DIV_SIGNED_EN
    neg_rem_in  = signed_i & dividend_i[WIDTH-1];
    neg_quot_in = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
    if (signed_i && dividend_i[WIDTH-1]) dividend_mag = '0 - dividend_i;
    if (signed_i && divisor_i[WIDTH-1])  divisor_mag  = '0 - divisor_i;
`endif
  end

  // One restoring step. The shifted remainder is below 2*divisor, so a true
  // non-negative difference always fits in WIDTH bits.
  always_comb begin
    shifted = {rem_q, quot_q[WIDTH-1]};
    if (shifted >= {1'b0, divisor_q}) begin
      rem_step  = shifted[WIDTH-1:0] - divisor_q;
      quot_step = {quot_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step  = shifted[WIDTH-1:0];
      quot_step = {quot_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix-up applied once on the last step; divide-by-zero always yields all ones.
  always_comb begin
    quot_final = neg_quot_q ? ('0 - quot_step) : quot_step;
    rem_final  = neg_rem_q  ? ('0 - rem_step)  : rem_step;
    if (div_zero_q) quot_final = '1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_valid_i)  state_d = BUSY;
        BUSY:    if (last_step)   state_d = DONE;
        DONE:    if (out_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: datapath registers are reset too, so outputs read zero after reset rather than stale data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      divisor_q  <= '0;
      div_zero_q <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (!flush_i) begin
      if (accept) begin
        cnt_q      <= '0;
        rem_q      <= '0;
        quot_q     <= dividend_mag;
        divisor_q  <= divisor_mag;
        div_zero_q <= (divisor_i == '0);
        neg_quot_q <= neg_quot_in;
        neg_rem_q  <= neg_rem_in;
      end else if (state_q == BUSY) begin
        cnt_q  <= cnt_q + 1'b1;
        rem_q  <= last_step ? rem_final  : rem_step;
        quot_q <= last_step ? quot_final : quot_step;
      end
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_int_div_seq.sv
// Directed self-checking bench for int_div_seq at WIDTH=8; inputs change and outputs are sampled 1 ns after rising edges.
module tb_int_div_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;
`ifdef DIV_SIGNED_EN
  logic         signed_op = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  int_div_seq #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .div_zero_o  (div_zero)
`ifdef DIV_SIGNED_EN
    ,
    .signed_i    (signed_op)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for exactly one edge; caller is in IDLE at posedge+1.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Bounded wait for out_valid; returns edges elapsed since the accept edge.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({in_ready, out_valid, quotient, remainder, div_zero} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b q=%h r=%h dz=%b want rdy=1 vld=0 q=00 r=00 dz=0",
               in_ready, out_valid, quotient, remainder, div_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    accept(8'd100, 8'd7);
    wait_valid(cyc);
    n_checks++;
    if (cyc !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d want 8", cyc); end
    n_checks++;
    if ({quotient, remainder, div_zero} !== {8'd14, 8'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_result: got q=%0d r=%0d dz=%b want q=14 r=2 dz=0", quotient, remainder, div_zero);
    end
    handshake();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    accept(8'd55, 8'd0);
    wait_valid(cyc);
    n_checks++;
    if (cyc !== 8) begin n_fail++; $display("FAIL divzero_latency: got %0d want 8", cyc); end
    n_checks++;
    if ({quotient, remainder, div_zero} !== {8'hFF, 8'd55, 1'b1}) begin
      n_fail++;
      $display("FAIL divzero_result: got q=%h r=%0d dz=%b want q=ff r=55 dz=1", quotient, remainder, div_zero);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int cyc;
    accept(8'd200, 8'd3);
    wait_valid(cyc);
    n_checks++;
    if (cyc !== 8) begin n_fail++; $display("FAIL bp_latency: got %0d want 8", cyc); end
    // A waiting operand must not be taken while the result is held.
    in_valid = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd2;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({out_valid, in_ready, quotient, remainder} !== {1'b1, 1'b0, 8'd66, 8'd2}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b q=%0d r=%0d want vld=1 rdy=0 q=66 r=2",
                 i, out_valid, in_ready, quotient, remainder);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_handshake: got rdy=%b vld=%b want rdy=1 vld=0 (no accept on handshake edge)",
               in_ready, out_valid);
    end
  endtask

  task automatic test_abort();
    int cyc;
    int seen;
    accept(8'd9, 8'd2);
    repeat (3) tick();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    n_checks++;
    if ({in_ready, out_valid, quotient, remainder} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL abort_reset: got rdy=%b vld=%b q=%h r=%h want rdy=1 vld=0 q=00 r=00",
               in_ready, out_valid, quotient, remainder);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (out_valid) seen++; end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL abort_reset_novalid: got %0d valid cycles want 0", seen); end

    accept(8'd9, 8'd2);
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_flush: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (out_valid) seen++; end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL abort_flush_novalid: got %0d valid cycles want 0", seen); end

    accept(8'd9, 8'd2);
    wait_valid(cyc);
    n_checks++;
    if ({cyc[7:0], quotient, remainder} !== {8'd8, 8'd4, 8'd1}) begin
      n_fail++;
      $display("FAIL abort_recover: got cyc=%0d q=%0d r=%0d want cyc=8 q=4 r=1", cyc, quotient, remainder);
    end
    handshake();
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    int cyc;
    signed_op = 1'b1;
    accept(8'hF9, 8'h02);
    wait_valid(cyc);
    n_checks++;
    if ({cyc[7:0], quotient, remainder} !== {8'd8, 8'hFD, 8'hFF}) begin
      n_fail++;
      $display("FAIL signed_neg7_2: got cyc=%0d q=%h r=%h want cyc=8 q=fd r=ff", cyc, quotient, remainder);
    end
    handshake();
    accept(8'h80, 8'hFF);
    wait_valid(cyc);
    n_checks++;
    if ({quotient, remainder} !== {8'h80, 8'h00}) begin
      n_fail++;
      $display("FAIL signed_min_m1: got q=%h r=%h want q=80 r=00", quotient, remainder);
    end
    handshake();
    signed_op = 1'b0;
  endtask
`endif

  task automatic test_back_to_back();
    int cyc;
    out_ready = 1'b1;
    accept(8'd255, 8'd255);
    wait_valid(cyc);
    n_checks++;
    if ({cyc[7:0], quotient, remainder} !== {8'd8, 8'd1, 8'd0}) begin
      n_fail++;
      $display("FAIL b2b_first: got cyc=%0d q=%0d r=%0d want cyc=8 q=1 r=0", cyc, quotient, remainder);
    end
    in_valid = 1'b1;
    dividend = 8'd0;
    divisor  = 8'd1;
    tick();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_handshake: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept: got rdy=%b want 0", in_ready); end
    wait_valid(cyc);
    n_checks++;
    if ({cyc[7:0], quotient, remainder} !== {8'd8, 8'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL b2b_second: got cyc=%0d q=%0d r=%0d want cyc=8 q=0 r=0", cyc, quotient, remainder);
    end
    tick();
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_drain: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_abort();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
